dmem_responder: RTL and testbench

- Data-memory responder on the far end of the load/store interface driven by the memory-access pipeline stage.
- Accepts one word-addressed request at a time from the stage: chip-enable, write-enable, byte selects, address and write data.
- Inserts a configurable number of wait states, performs the byte-lane write or word read, and returns a one-cycle acknowledge with read data.
- Drives a stall request back to the pipeline until the access completes.

---
 rtl/dmem_responder_pkg.sv | 41 ++++
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_responder.sv | 124 ++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared FSM encodings, lane-select and word constants for the
//               data-memory responder.
// Revision    : 1.0
// ============================================================================
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_ACK  = 2'd2
    } dmem_state_e;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_B0      = 4'b0001;
    localparam logic [3:0] SEL_B1      = 4'b0010;
    localparam logic [3:0] SEL_B2      = 4'b0100;
    localparam logic [3:0] SEL_B3      = 4'b1000;

    function automatic logic sel_legal(input logic [3:0] sel);
        logic ok;
        case (sel)
            SEL_WORD, SEL_HALF_HI, SEL_HALF_LO,
            SEL_B0, SEL_B1, SEL_B2, SEL_B3: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : 2**ADDR_W x 32 single-port storage, per-lane write enables,
//               registered read.
// Revision    : 1.0
// ============================================================================
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        wen_i,
    input  logic              ren_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (ren_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wen_i[i] == WriteEnable) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Wait-state data-memory responder with one-cycle ack and stall
//               request; DMEM_ALIGN_CHECK_EN enables byte-select legality check.
// Revision    : 1.0
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        stallreq_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    dmem_state_e       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              load_q, load_d;
    logic              enter_ack;
    logic              sel_ok;
    logic [3:0]        wen;
    logic              ren;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] word_idx;
    logic              unused_addr;

    assign word_idx    = mem_addr_i[ADDR_W+1:2];
    assign unused_addr = ^{mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign sel_ok = sel_legal(mem_sel_i);
`else
    assign sel_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enter_ack = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                if (mem_ce_i == ChipEnable) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d   = DMEM_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = DMEM_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            DMEM_WAIT: begin
                // A withdrawn request abandons the access before any write.
                if (mem_ce_i == ChipDisable) begin
                    state_d = DMEM_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = DMEM_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            DMEM_ACK: state_d = DMEM_IDLE;
            default:  state_d = DMEM_IDLE;
        endcase

        ack_d  = enter_ack;
        err_d  = enter_ack & ~sel_ok;
        load_d = enter_ack & (mem_we_i == WriteDisable) & sel_ok;
        ren    = enter_ack & (mem_we_i == WriteDisable);
        wen    = (enter_ack && mem_we_i == WriteEnable && sel_ok && !rst) ? mem_sel_i : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .addr_i  (word_idx),
        .wen_i   (wen),
        .ren_i   (ren),
        .wdata_i (mem_data_i),
        .rdata_o (rdata)
    );

    assign mem_data_o = load_q ? rdata : ZeroWord;
    assign mem_ack_o  = ack_q;
    assign mem_err_o  = err_q;
    assign stallreq_o = mem_ce_i & ~ack_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder at WAIT_CYCLES=2 and 0.
// Revision    : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int W = 2;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t sb[$];
    exp_t zsb[$];

    logic        ce, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack, err, stall;

    logic        z_ce, z_we;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_sel;
    logic [31:0] z_rdata;
    logic        z_ack, z_err, z_stall;

    logic ack_prev = 1'b0;
    logic z_ack_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_ce_i(ce), .mem_we_i(we), .mem_addr_i(addr),
        .mem_sel_i(sel), .mem_data_i(wdata), .mem_data_o(rdata), .mem_ack_o(ack),
        .mem_err_o(err), .stallreq_o(stall)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .mem_ce_i(z_ce), .mem_we_i(z_we), .mem_addr_i(z_addr),
        .mem_sel_i(z_sel), .mem_data_i(z_wdata), .mem_data_o(z_rdata), .mem_ack_o(z_ack),
        .mem_err_o(z_err), .stallreq_o(z_stall)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Monitor for the wait-state instance
    always @(negedge clk) begin
        exp_t e;
        chk("stallreq", {31'd0, stall}, {31'd0, ce & ~ack});
        if (ack === 1'b1) begin
            chk("ack_pulse_width", {31'd0, ack_prev}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", rdata, e.data);
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("latency", cyc, e.cyc);
            end
        end else begin
            chk("rdata_idle", rdata, 32'd0);
        end
        ack_prev = ack;
    end

    // Monitor for the zero-wait instance
    always @(negedge clk) begin
        exp_t e;
        chk("z_stallreq", {31'd0, z_stall}, {31'd0, z_ce & ~z_ack});
        if (z_ack === 1'b1) begin
            chk("z_ack_pulse_width", {31'd0, z_ack_prev}, 32'd0);
            if (zsb.size() == 0) begin
                chk("z_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = zsb.pop_front();
                chk("z_rdata", z_rdata, e.data);
                chk("z_latency", cyc, e.cyc);
            end
        end
        z_ack_prev = z_ack;
    end

    // Starts and ends one cycle-phase after a rising edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
        exp_t e;
        int   n;
        e.data = exp_d;
        e.err  = exp_e;
        e.cyc  = cyc + W + 1;
        sb.push_back(e);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack !== 1'b1 && n < 40);
        if (ack !== 1'b1) chk("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   base;
        rst = 1'b1;
        ce = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
        z_ce = 1'b0; z_we = 1'b0; z_addr = '0; z_sel = '0; z_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", {31'd0, ack}, 32'd0);
        chk("reset_data", rdata, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_z_ack", {31'd0, z_ack}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        xfer(1'b1, 32'h40, 4'b1111, 32'h1111_1111, 32'h0, 1'b0);

        // Store begins, then reset lands mid-wait and is held 3 cycles.
        ce = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'b1111; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_hold_ack", {31'd0, ack}, 32'd0);
            chk("rst_hold_data", rdata, 32'd0);
            chk("rst_hold_stall", {31'd0, stall}, 32'd1);
        end
        rst = 1'b0; ce = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        xfer(1'b0, 32'h40, 4'b1111, 32'h0, 32'h1111_1111, 1'b0);

        xfer(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 4'b0001, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b1, 32'h10, 4'b0001, 32'h0000_00AA, 32'h0, 1'b0);
        xfer(1'b1, 32'h10, 4'b1100, 32'h5566_0000, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 4'b1111, 32'h0, 32'h5566_BEAA, 1'b0);

        // Upper address bits alias onto word 0x10 >> 2.
        xfer(1'b1, 32'h0000_1010, 4'b1111, 32'h0102_0304, 32'h0, 1'b0);
        xfer(1'b0, 32'h10, 4'b1111, 32'h0, 32'h0102_0304, 1'b0);
        xfer(1'b1, 32'hFFC, 4'b1111, 32'h7777_0001, 32'h0, 1'b0);
        xfer(1'b0, 32'hFFC, 4'b1111, 32'h0, 32'h7777_0001, 1'b0);

        // Abort: request withdrawn in the second wait cycle.
        xfer(1'b1, 32'h20, 4'b1111, 32'hA5A5_A5A5, 32'h0, 1'b0);
        ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'b1111; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        xfer(1'b0, 32'h20, 4'b1111, 32'h0, 32'hA5A5_A5A5, 1'b0);

        // Non-contiguous lane select.
        xfer(1'b1, 32'h30, 4'b1111, 32'h0, 32'h0, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
        xfer(1'b1, 32'h30, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer(1'b0, 32'h30, 4'b1111, 32'h0, 32'h0, 1'b0);
`else
        xfer(1'b1, 32'h30, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer(1'b0, 32'h30, 4'b1111, 32'h0, 32'h00FF_00FF, 1'b0);
`endif

        // Zero-wait instance: one store, then a continuous run of loads.
        e.data = 32'h0; e.err = 1'b0; e.cyc = cyc + 1;
        zsb.push_back(e);
        z_ce = 1'b1; z_we = 1'b1; z_addr = 32'h8; z_sel = 4'b1111; z_wdata = 32'h0BEE_F123;
        @(posedge clk); #1;
        @(posedge clk); #1;
        z_ce = 1'b0; z_we = 1'b0;
        @(posedge clk); #1;
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            e.data = 32'h0BEE_F123; e.err = 1'b0; e.cyc = base + 1 + 2 * k;
            zsb.push_back(e);
        end
        z_ce = 1'b1; z_we = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        z_ce = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);
        chk("zsb_drained", zsb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
